// File: rtl/run_ctrl_pkg.sv
// Shared types and constants for the run/display controller and its helpers.
package run_ctrl_pkg;

   typedef enum logic [2:0] {IDLE, ARM, RUN, SHOW, ERR} run_state_t;

   localparam int                DISP_W      = 24;
   localparam logic [DISP_W-1:0] ERR_PATTERN = 24'hEEEEEE;
   localparam logic [5:0]        DIGITS_ON   = 6'b111111;
   localparam logic [5:0]        DIGITS_OFF  = 6'b000000;

   function automatic logic [DISP_W-1:0] sat_inc(input logic [DISP_W-1:0] v);
      return (v == {DISP_W{1'b1}}) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/key_debouncer.sv
// Two-flop synchronizer plus down-counter debounce for an active-low key;
// emits a one-cycle pulse when the debounced level falls (press).
module key_debouncer #(
   parameter int DEBOUNCE_CYCLES = 500_000
) (
   input  logic clk,
   input  logic reset,
   input  logic key_n,
   output logic press_pulse
);

   localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]       sync_q;
   logic             level_q;
   logic [CNT_W-1:0] cnt_q;
   logic             key_s;

   assign key_s = sync_q[1];

   // Any sample equal to the accepted level restarts the run of differing samples.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q      <= 2'b11;
         level_q     <= 1'b1;
         cnt_q       <= CNT_LOAD;
         press_pulse <= 1'b0;
      end else begin
         sync_q      <= {sync_q[0], key_n};
         press_pulse <= 1'b0;
         if (key_s == level_q) begin
            cnt_q <= CNT_LOAD;
         end else if (cnt_q == '0) begin
            level_q     <= key_s;
            cnt_q       <= CNT_LOAD;
            press_pulse <= level_q & ~key_s;
         end else begin
            cnt_q <= cnt_q - 1'b1;
         end
      end
   end

endmodule

// File: rtl/run_display_controller.sv
// Push-button sequencer for one accelerator run: reset pulse, cycle count with
// timeout, result latch and six-digit display select.
//
//  state | meaning
//  IDLE  | after reset; DUT held in reset, display dark
//  ARM   | DUT held in reset for RST_CYCLES cycles
//  RUN   | DUT released, counting cycles until done or timeout
//  SHOW  | results latched, DUT left running to hold its outputs
//  ERR   | timed out; DUT back in reset, display shows EEEEEE
module run_display_controller
   import run_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500_000,
   parameter int RST_CYCLES      = 16,
   parameter int TIMEOUT_CYCLES  = 2**20
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start_key_n,
   input  logic              page_sel,
   input  logic              dut_done,
   input  logic [DISP_W-1:0] dut_sum,
   input  logic [9:0]        dut_cycle,
   output logic              dut_reset_n,
   output logic              busy,
   output logic              timeout,
   output logic [DISP_W-1:0] disp_value,
   output logic [5:0]        disp_on,
   output logic              dut_cyc_mismatch
);

   localparam int               RST_W        = $clog2(RST_CYCLES + 1);
   localparam logic [RST_W-1:0] RST_LOAD     = RST_W'(RST_CYCLES - 1);
   localparam logic [DISP_W-1:0] TIMEOUT_LAST = DISP_W'(TIMEOUT_CYCLES - 1);

   run_state_t        state_q, state_d;
   logic              start_pulse;
   logic [RST_W-1:0]  rst_cnt_q;
   logic [DISP_W-1:0] run_cnt_q;
   logic [DISP_W-1:0] run_cnt_inc;
   logic [DISP_W-1:0] sum_q;
   logic [DISP_W-1:0] cycles_q;
   logic              mismatch_q;
   logic [DISP_W-1:0] disp_value_q;
   logic [5:0]        disp_on_q;
   logic              capture;

   key_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_start_key (
      .clk         (clk),
      .reset       (reset),
      .key_n       (start_key_n),
      .press_pulse (start_pulse)
   );

   // run_cnt_q holds completed RUN cycles, so the current cycle's count is one more.
   assign run_cnt_inc = sat_inc(run_cnt_q);
   assign capture     = (state_q == RUN) && dut_done;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start_pulse) state_d = ARM;
         ARM:     if (rst_cnt_q == '0) state_d = RUN;
         RUN: begin
            if (dut_done)                        state_d = SHOW;
            else if (run_cnt_q == TIMEOUT_LAST)  state_d = ERR;
         end
         SHOW:    if (start_pulse) state_d = ARM;
         ERR:     if (start_pulse) state_d = ARM;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rst_cnt_q  <= RST_LOAD;
         run_cnt_q  <= '0;
         sum_q      <= '0;
         cycles_q   <= '0;
         mismatch_q <= 1'b0;
      end else begin
         if (state_q != ARM)        rst_cnt_q <= RST_LOAD;
         else if (rst_cnt_q != '0)  rst_cnt_q <= rst_cnt_q - 1'b1;

         if (state_q == ARM)        run_cnt_q <= '0;
         else if (state_q == RUN)   run_cnt_q <= run_cnt_inc;

         if (capture) begin
            sum_q      <= dut_sum;
            cycles_q   <= run_cnt_inc;
            mismatch_q <= (run_cnt_inc[9:0] != dut_cycle);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         disp_value_q <= '0;
         disp_on_q    <= DIGITS_OFF;
      end else begin
         unique case (state_q)
            IDLE: begin
               disp_value_q <= '0;
               disp_on_q    <= DIGITS_OFF;
            end
            ERR: begin
               disp_value_q <= ERR_PATTERN;
               disp_on_q    <= DIGITS_ON;
            end
            default: begin
               disp_value_q <= page_sel ? cycles_q : sum_q;
               disp_on_q    <= DIGITS_ON;
            end
         endcase
      end
   end

   assign dut_reset_n      = (state_q == RUN) || (state_q == SHOW);
   assign busy             = (state_q == ARM) || (state_q == RUN);
   assign timeout          = (state_q == ERR);
   assign disp_value       = disp_value_q;
   assign disp_on          = disp_on_q;
   assign dut_cyc_mismatch = mismatch_q;

endmodule

// File: tb/tb_run_display_controller.sv
// Bench for run_display_controller: table-driven runs, hand-written corner
// sequences and randomized runs against a run-level reference model.
module tb_run_display_controller;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start_key_n = 1'b1;
   logic        page_sel = 1'b0;
   logic        dut_done = 1'b0;
   logic [23:0] dut_sum = '0;
   logic [9:0]  dut_cycle = '0;
   logic        dut_reset_n, busy, timeout, dut_cyc_mismatch;
   logic [23:0] disp_value;
   logic [5:0]  disp_on;

   int checks = 0;
   int failures = 0;

   // reference model: what the controller should be holding after each run
   logic [23:0] m_sum = '0;
   logic [23:0] m_cyc = '0;
   logic        m_mm = 1'b0;

   localparam int TMO = 100;

   run_display_controller #(
      .DEBOUNCE_CYCLES (4),
      .RST_CYCLES      (3),
      .TIMEOUT_CYCLES  (TMO)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .start_key_n      (start_key_n),
      .page_sel         (page_sel),
      .dut_done         (dut_done),
      .dut_sum          (dut_sum),
      .dut_cycle        (dut_cycle),
      .dut_reset_n      (dut_reset_n),
      .busy             (busy),
      .timeout          (timeout),
      .disp_value       (disp_value),
      .disp_on          (disp_on),
      .dut_cyc_mismatch (dut_cyc_mismatch)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          done_at;   // RUN cycle carrying done; 0 = never
      logic [23:0] sum;
      logic [9:0]  dcyc;
      logic        page;
      int          exp_len;
      logic        exp_err;
      logic [23:0] exp_disp;
      logic        exp_mm;
   } vec_t;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic apply_model(input int done_at, input logic [23:0] s, input logic [9:0] dc);
      if (done_at >= 1 && done_at <= TMO) begin
         m_sum = s;
         m_cyc = 24'(done_at);
         m_mm  = (done_at % 1024) != int'(dc);
      end
   endtask

   // Press the key, wait for RUN, present done on RUN cycle done_at, return run length.
   task automatic do_run(input int done_at, input logic [23:0] s, input logic [9:0] dc,
                         input int mid_press, output int run_len, output int arm_len);
      int n = 0;
      int rc = 1;
      run_len = 0;
      arm_len = 0;
      start_key_n = 1'b0;
      while (!(busy && dut_reset_n) && n < 60) begin
         step();
         n++;
         if (n == 10) start_key_n = 1'b1;
         if (busy && !dut_reset_n) arm_len++;
      end
      if (n >= 60) begin
         chk("run_start_bound", 32'd0, 32'd1);
         start_key_n = 1'b1;
         return;
      end
      chk("old_disp_at_run_start", disp_value, page_sel ? m_cyc : m_sum);
      while (rc <= 200) begin
         if (rc == done_at) begin
            dut_done  = 1'b1;
            dut_sum   = s;
            dut_cycle = dc;
         end
         if (mid_press > 0 && rc == mid_press)      start_key_n = 1'b0;
         if (mid_press > 0 && rc == mid_press + 10) start_key_n = 1'b1;
         step();
         n++;
         if (n == 10) start_key_n = 1'b1;
         dut_done  = 1'b0;
         dut_sum   = $urandom;
         dut_cycle = 10'($urandom);
         if (!busy) begin
            run_len = rc;
            break;
         end
         rc++;
      end
      if (run_len == 0) chk("run_end_bound", 32'd0, 32'd1);
      start_key_n = 1'b1;
      repeat (10) step();
   endtask

   task automatic check_result(input string tag, input logic page, input logic err,
                               input logic [23:0] exp_disp, input logic exp_mm);
      page_sel = page;
      step();
      step();
      chk({tag, "_timeout"}, timeout, err);
      chk({tag, "_dut_reset_n"}, dut_reset_n, !err);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_disp_on"}, disp_on, 6'h3F);
      chk({tag, "_disp_value"}, disp_value, exp_disp);
      chk({tag, "_mismatch"}, dut_cyc_mismatch, exp_mm);
   endtask

   vec_t vecs[7];

   initial begin
      int len, al, seen, n;
      logic [23:0] exp_disp;

      vecs[0] = '{7,   24'h12AB34, 10'd7,   1'b0, 7,   1'b0, 24'h12AB34, 1'b0};
      vecs[1] = '{7,   24'h12AB34, 10'd7,   1'b1, 7,   1'b0, 24'h000007, 1'b0};
      vecs[2] = '{7,   24'h12AB34, 10'd9,   1'b0, 7,   1'b0, 24'h12AB34, 1'b1};
      vecs[3] = '{0,   24'h000000, 10'd0,   1'b0, 100, 1'b1, 24'hEEEEEE, 1'b1};
      vecs[4] = '{100, 24'hABCDEF, 10'd100, 1'b1, 100, 1'b0, 24'h000064, 1'b0};
      vecs[5] = '{1,   24'h000001, 10'd1,   1'b1, 1,   1'b0, 24'h000001, 1'b0};
      vecs[6] = '{99,  24'h0F0F0F, 10'd5,   1'b0, 99,  1'b0, 24'h0F0F0F, 1'b1};

      repeat (3) step();
      reset = 1'b0;
      step();
      chk("rst_dut_reset_n", dut_reset_n, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_timeout", timeout, 1'b0);
      chk("rst_disp_on", disp_on, 6'h00);
      chk("rst_disp_value", disp_value, 24'h0);
      chk("rst_mismatch", dut_cyc_mismatch, 1'b0);

      // too-short press must not start anything
      seen = 0;
      start_key_n = 1'b0;
      repeat (3) step();
      start_key_n = 1'b1;
      repeat (15) begin
         step();
         if (busy) seen++;
      end
      chk("short_press_ignored", seen, 0);
      chk("idle_disp_dark", disp_on, 6'h00);

      foreach (vecs[i]) begin
         page_sel = vecs[i].page;
         do_run(vecs[i].done_at, vecs[i].sum, vecs[i].dcyc, 0, len, al);
         apply_model(vecs[i].done_at, vecs[i].sum, vecs[i].dcyc);
         chk($sformatf("vec%0d_arm_len", i), al, 3);
         chk($sformatf("vec%0d_run_len", i), len, vecs[i].exp_len);
         check_result($sformatf("vec%0d", i), vecs[i].page, vecs[i].exp_err,
                      vecs[i].exp_disp, vecs[i].exp_mm);
      end

      // a press during RUN must not restart the run
      page_sel = 1'b0;
      do_run(80, 24'h55AA55, 10'd80, 30, len, al);
      apply_model(80, 24'h55AA55, 10'd80);
      chk("midpress_run_len", len, 80);
      check_result("midpress", 1'b0, 1'b0, 24'h55AA55, 1'b0);

      // asynchronous reset in the middle of RUN
      start_key_n = 1'b0;
      n = 0;
      while (!(busy && dut_reset_n) && n < 60) begin
         step();
         n++;
         if (n == 10) start_key_n = 1'b1;
      end
      chk("rst_mid_run_reached_run", busy && dut_reset_n, 1'b1);
      repeat (5) step();
      start_key_n = 1'b1;
      reset = 1'b1;
      #1;
      chk("async_rst_dut_reset_n", dut_reset_n, 1'b0);
      chk("async_rst_busy", busy, 1'b0);
      chk("async_rst_disp_on", disp_on, 6'h00);
      chk("async_rst_disp_value", disp_value, 24'h0);
      chk("async_rst_mismatch", dut_cyc_mismatch, 1'b0);
      step();
      reset = 1'b0;
      m_sum = '0;
      m_cyc = '0;
      m_mm  = 1'b0;
      repeat (12) step();
      chk("post_rst_idle_busy", busy, 1'b0);
      chk("post_rst_idle_disp_on", disp_on, 6'h00);

      // randomized runs against the run-level model
      for (int r = 0; r < 12; r++) begin
         int d;
         logic [23:0] s;
         logic [9:0]  dc;
         logic        pg;
         d  = $urandom_range(1, 115);
         s  = $urandom;
         dc = ($urandom_range(0, 1) == 1) ? 10'(d) : 10'($urandom);
         pg = 1'($urandom_range(0, 1));
         page_sel = pg;
         do_run(d, s, dc, 0, len, al);
         apply_model(d, s, dc);
         chk($sformatf("rnd%0d_run_len", r), len, (d <= TMO) ? d : TMO);
         exp_disp = (d > TMO) ? 24'hEEEEEE : (pg ? m_cyc : m_sum);
         check_result($sformatf("rnd%0d", r), pg, d > TMO, exp_disp, m_mm);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
